// File: rtl/offload_pack.sv
// Packs a stream of REG_SIZE-bit host words into one 16-word offload packet.
// Words NUM_REGS..14 are zero and word 15 carries PKT_MAGIC.
module offload_pack #(
    parameter int                   NUM_REGS  = 14,
    parameter int                   REG_SIZE  = 32,
    parameter logic [REG_SIZE-1:0]  PKT_MAGIC = 32'h0FFA0FFB
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [REG_SIZE-1:0]      s_axis_tdata,
    input  logic [REG_SIZE/8-1:0]    s_axis_tkeep,
    input  logic                     s_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [16*REG_SIZE-1:0]   m_axis_tdata,
    output logic [2*REG_SIZE-1:0]    m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic [15:0]              pkt_count,
    output logic [7:0]               short_count,
    output logic [3:0]               dbg
);
    localparam int             IW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int             PAD      = 16 - NUM_REGS;
    localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_REGS - 1);

    logic [NUM_REGS-1:0][REG_SIZE-1:0] asm_q, asm_d;
    logic                              asm_last_q, asm_last_d;
    logic                              asm_full_q, asm_full_d;
    logic [IW-1:0]                     idx_q, idx_d;
    logic                              tready_q, tready_d;
    logic                              m_valid_q, m_valid_d;
    logic [16*REG_SIZE-1:0]            m_data_q, m_data_d;
    logic [2*REG_SIZE-1:0]             m_keep_q, m_keep_d;
    logic                              m_last_q, m_last_d;
    logic [15:0]                       pkt_q, pkt_d;
    logic [7:0]                        short_q, short_d;
    logic                              seen_q, seen_d;

    logic [REG_SIZE-1:0] masked;
    logic                accept, xfer, hs;

    always_comb begin
        masked = s_axis_tdata;
        for (int b = 0; b < REG_SIZE/8; b++)
            if (!s_axis_tkeep[b]) masked[b*8 +: 8] = 8'h00;

        accept = s_axis_tvalid & tready_q;
        xfer   = asm_full_q & (!m_valid_q | m_axis_tready);
        hs     = m_valid_q & m_axis_tready;

        asm_d      = asm_q;
        asm_last_d = asm_last_q;
        asm_full_d = asm_full_q;
        idx_d      = idx_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_keep_d   = m_keep_q;
        m_last_d   = m_last_q;
        pkt_d      = pkt_q;
        short_d    = short_q;
        seen_d     = seen_q;

        // Clearing the buffer on transfer is what zero-pads short packets.
        if (xfer) begin
            m_data_d   = {PKT_MAGIC, {(PAD-1)*REG_SIZE{1'b0}}, asm_q};
            m_last_d   = asm_last_q;
            m_keep_d   = '1;
            m_valid_d  = 1'b1;
            asm_full_d = 1'b0;
            asm_d      = '0;
        end else if (hs) begin
            m_valid_d  = 1'b0;
        end

        if (hs) pkt_d = pkt_q + 16'd1;

        // accept and xfer are exclusive: accept needs !asm_full, xfer needs asm_full.
        if (accept) begin
            asm_d[idx_q] = masked;
            if (idx_q == LAST_IDX || s_axis_tlast) begin
                asm_full_d = 1'b1;
                asm_last_d = s_axis_tlast;
                idx_d      = '0;
                if (s_axis_tlast && idx_q != LAST_IDX) begin
                    seen_d = 1'b1;
                    if (short_q != 8'hFF) short_d = short_q + 8'd1;
                end
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        // Registered ready so it reads 0 during reset and rises one cycle after release.
        tready_d = !asm_full_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            asm_q      <= '0;
            asm_last_q <= 1'b0;
            asm_full_q <= 1'b0;
            idx_q      <= '0;
            tready_q   <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_keep_q   <= '0;
            m_last_q   <= 1'b0;
            pkt_q      <= '0;
            short_q    <= '0;
            seen_q     <= 1'b0;
        end else begin
            asm_q      <= asm_d;
            asm_last_q <= asm_last_d;
            asm_full_q <= asm_full_d;
            idx_q      <= idx_d;
            tready_q   <= tready_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_keep_q   <= m_keep_d;
            m_last_q   <= m_last_d;
            pkt_q      <= pkt_d;
            short_q    <= short_d;
            seen_q     <= seen_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tlast  = m_last_q;
    assign pkt_count     = pkt_q;
    assign short_count   = short_q;
    assign dbg           = {m_valid_q & !m_axis_tready, seen_q, m_valid_q, asm_full_q};

endmodule

// File: tb/tb_offload_pack.sv
// Scoreboard bench for offload_pack: stimulus pushes expected packets, a
// negedge monitor pops and compares on every output handshake.
module tb_offload_pack;
    localparam logic [31:0] MAGIC = 32'h0FFA0FFB;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic [31:0]  s_tdata = '0;
    logic [3:0]   s_tkeep = '0;
    logic         s_tlast = 1'b0;
    logic         m_tvalid;
    logic         m_tready = 1'b1;
    logic [511:0] m_tdata;
    logic [63:0]  m_tkeep;
    logic         m_tlast;
    logic [15:0]  pkt_count;
    logic [7:0]   short_count;
    logic [3:0]   dbg;

    always #5 clk = ~clk;

    offload_pack dut (
        .clk(clk), .reset_n(reset_n),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
        .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
        .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .pkt_count(pkt_count), .short_count(short_count), .dbg(dbg)
    );

    typedef struct packed {
        logic [511:0] data;
        logic         last;
    } pkt_t;

    pkt_t             exp_q[$];
    logic [13:0][31:0] mbuf = '0;
    int               midx = 0;
    int               checks = 0;
    int               failures = 0;
    bit               sent_done;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out", name);
    endtask

    // e is the hand-computed stored value of the word (after tkeep masking).
    task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l,
                             input logic [31:0] e);
        bit   ok;
        logic r;
        ok = 0;
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
        for (int c = 0; c < 500 && !ok; c++) begin
            @(negedge clk); r = s_tready;
            @(posedge clk); #1;
            ok = r;
        end
        s_tvalid = 1'b0;
        if (!ok) timeout("send_word");
        else begin
            mbuf[midx] = e;
            if (l || midx == 13) begin
                exp_q.push_back(pkt_t'({MAGIC, 32'h0, mbuf, l}));
                mbuf = '0;
                midx = 0;
            end else midx++;
        end
    endtask

    task automatic check_zero();
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_m_tkeep", m_tkeep, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_short_count", short_count, 0);
        check("rst_dbg", dbg, 0);
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        s_tvalid = 1'b0;
        #1 check_zero();
        exp_q.delete();
        mbuf = '0;
        midx = 0;
        @(posedge clk); #3 reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(posedge clk); #1;
            ok = (exp_q.size() == 0) && !m_tvalid;
        end
        if (!ok) timeout(name);
    endtask

    // Monitor: compares at negedge, away from the active edge.
    initial begin
        pkt_t         e;
        logic [511:0] hold_d;
        logic [63:0]  hold_k;
        logic         hold_l;
        bit           stalled;
        stalled = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) stalled = 0;
            else begin
                if (stalled) begin
                    check("stall_valid", m_tvalid, 1);
                    check("stall_data", m_tdata, hold_d);
                    check("stall_last", m_tlast, hold_l);
                    check("stall_keep", m_tkeep, hold_k);
                end
                if (m_tvalid) begin
                    check("keep_ones", m_tkeep, 64'hFFFF_FFFF_FFFF_FFFF);
                    check("dbg_stall", dbg[3], !m_tready);
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_pkt actual=%0h required=none", m_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("pkt_data", m_tdata, e.data);
                        check("pkt_last", m_tlast, e.last);
                    end
                end
                stalled = m_tvalid && !m_tready;
                hold_d = m_tdata; hold_k = m_tkeep; hold_l = m_tlast;
            end
        end
    end

    initial begin
        #2 check_zero();
        #10 reset_n = 1'b1;
        @(posedge clk); #1;

        // 1: async reset mid-packet, then a clean full packet
        for (int i = 0; i < 7; i++) send_word(32'h50 + i, 4'hF, 1'b0, 32'h50 + i);
        do_reset();
        for (int i = 1; i <= 14; i++) send_word(i, 4'hF, 1'b0, i);
        drain("t1_drain");
        check("t1_pkt_count", pkt_count, 1);

        // 2: two back-to-back full packets and output latency
        do_reset();
        for (int i = 0; i < 14; i++) send_word(32'h100 + i, 4'hF, 1'b0, 32'h100 + i);
        check("t2_asm_full", dbg[0], 1);
        check("t2_valid_n1", m_tvalid, 0);
        @(posedge clk); #1;
        check("t2_valid_n2", m_tvalid, 1);
        for (int i = 14; i < 28; i++) send_word(32'h100 + i, 4'hF, i == 27, 32'h100 + i);
        drain("t2_drain");
        check("t2_pkt_count", pkt_count, 2);
        check("t2_short_count", short_count, 0);

        // 3: short packets
        do_reset();
        send_word(32'hA, 4'hF, 1'b0, 32'hA);
        send_word(32'hB, 4'hF, 1'b0, 32'hB);
        send_word(32'hC, 4'hF, 1'b1, 32'hC);
        drain("t3a_drain");
        check("t3_short1", short_count, 1);
        check("t3_sticky", dbg[2], 1);
        send_word(32'hD, 4'hF, 1'b1, 32'hD);
        drain("t3b_drain");
        check("t3_short2", short_count, 2);

        // 4: backpressure with three packets offered
        do_reset();
        m_tready = 1'b0;
        sent_done = 0;
        fork
            begin
                for (int i = 0; i < 42; i++) send_word(32'h400 + i, 4'hF, i == 41, 32'h400 + i);
                sent_done = 1;
            end
        join_none
        begin
            bit ok;
            ok = 0;
            for (int c = 0; c < 200 && !ok; c++) begin
                @(posedge clk); #1;
                ok = m_tvalid && dbg[0];
            end
            if (!ok) timeout("t4_fill");
        end
        repeat (5) @(posedge clk);
        #1;
        check("t4_s_tready", s_tready, 0);
        check("t4_dbg_stall", dbg[3], 1);
        check("t4_pkt_count_held", pkt_count, 0);
        m_tready = 1'b1;
        begin
            bit ok;
            ok = 0;
            for (int c = 0; c < 500 && !ok; c++) begin
                @(posedge clk); #1;
                ok = sent_done && exp_q.size() == 0 && !m_tvalid;
            end
            if (!ok) timeout("t4_drain");
        end
        check("t4_pkt_count", pkt_count, 3);

        // 5: tkeep masking
        do_reset();
        send_word(32'hDEADBEEF, 4'b0101, 1'b1, 32'h00AD00EF);
        drain("t5_drain");

        // 6: short_count saturation
        do_reset();
        for (int i = 0; i < 300; i++) send_word(32'h1000 + i, 4'hF, 1'b1, 32'h1000 + i);
        drain("t6_drain");
        check("t6_short_sat", short_count, 255);
        check("t6_pkt_count", pkt_count, 300);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
